// File: rtl/bpsk_pkg.sv
// bpsk_pkg -- constants and types shared by the BPSK modulator and demodulator.
// Holds the FSM state encoding, the default carrier/sample/word dimensions and
// the elaboration-time helper that builds the quarter-wave sine table.
package bpsk_pkg;

    localparam int DEF_SAMPLE_NUMBER = 256;
    localparam int DEF_SAMPLE_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH    = 12;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

    // Magnitude of the first-quadrant sine entry i for an n-point period and a
    // w-bit offset-binary sample (amplitude 2^(w-1)-1, rounded to nearest).
    function automatic int quarter_sine(input int i, input int n, input int w);
        real amp;
        amp = real'((1 << (w - 1)) - 1);
        return $rtoi(amp * $sin(2.0 * PI * real'(i) / real'(n)) + 0.5);
    endfunction

endpackage

// File: rtl/bpsk_modulator_sine_lut.sv
// sine_lut -- registered carrier table for the BPSK modulator.
// Only the first quadrant is stored; the other three are folded from it by
// index mirroring and sign flipping about midscale. 'value' is the raw
// combinational lookup of idx, 'sine'/'neg_sine' are its registered forms.
module sine_lut
    import bpsk_pkg::*;
#(
    parameter  int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
    parameter  int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    localparam int CW            = $clog2(SAMPLE_NUMBER)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [CW-1:0]           idx,
    output logic [SAMPLE_WIDTH-1:0] value,
    output logic [SAMPLE_WIDTH-1:0] sine,
    output logic [SAMPLE_WIDTH-1:0] neg_sine
);

    localparam int QN = SAMPLE_NUMBER / 4;
    localparam logic [SAMPLE_WIDTH-1:0] MID = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    // NOTE: the table is a constant ROM, so it has no reset; only the output
    // registers below are reset.
    logic [SAMPLE_WIDTH-2:0] quarter [0:QN];

    for (genvar i = 0; i <= QN; i++) begin : g_quarter
        localparam logic [SAMPLE_WIDTH-2:0] QV =
            (SAMPLE_WIDTH-1)'(quarter_sine(i, SAMPLE_NUMBER, SAMPLE_WIDTH));
        assign quarter[i] = QV;
    end

    logic [1:0]      quad;
    logic [CW-3:0]   off;
    logic [CW-2:0]   q_idx;
    logic [SAMPLE_WIDTH-2:0] mag;

    // Fold the full-period index onto the stored quadrant and restore the sign.
    always_comb begin
        quad  = idx[CW-1:CW-2];
        off   = idx[CW-3:0];
        q_idx = quad[0] ? ((CW-1)'(QN) - {1'b0, off}) : {1'b0, off};
        mag   = quarter[q_idx];
        value = quad[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
    end

    // Register the carrier and its complement on every enabled sample.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst) begin
            sine     <= MID;
            neg_sine <= ~MID;
        end else if (en) begin
            sine     <= value;
            neg_sine <= ~value;
        end
    end

endmodule

// File: rtl/bpsk_modulator.sv
// bpsk_modulator -- serialises DATA_WIDTH-bit words LSB first onto a sine
// carrier, one carrier period of SAMPLE_NUMBER samples per bit. A '1' sends the
// carrier, a '0' sends its complement. Words are accepted through a
// valid/ready handshake that opens on the very last sample of a word, so
// consecutive words stream without a gap.
// Optional build macro: BPSK_DIFF_EN -- differential encoding, the transmitted
// bit is the data bit XOR the previously transmitted bit.
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter  int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
    parameter  int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
    localparam int CW            = $clog2(SAMPLE_NUMBER),
    localparam int BW            = $clog2(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [SAMPLE_WIDTH-1:0] signal_out,
    output logic [SAMPLE_WIDTH-1:0] sine_out,
    output logic [SAMPLE_WIDTH-1:0] neg_sine_out,
    output logic [CW-1:0]           cnt_out,
    output logic                    busy
);

    localparam logic [SAMPLE_WIDTH-1:0] MID = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_NUMBER - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    state_t                  state, next_state;
    logic [CW-1:0]           cnt, next_cnt;
    logic [BW-1:0]           bit_idx, next_bit_idx;
    logic [DATA_WIDTH-1:0]   shreg, next_shreg;
    logic                    accept;
    logic                    tx_bit;
    logic [SAMPLE_WIDTH-1:0] lut_value;

    assign data_ready = (state == IDLE) ||
                        ((state == TX) && (cnt == CNT_LAST) && (bit_idx == BIT_LAST) && en);
    assign accept     = en && data_valid && data_ready;
    assign cnt_out    = cnt;
    assign busy       = (state == TX);

    // Next-state logic: accept a word, step through samples and bits, or retire.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state   = state;
        next_cnt     = cnt;
        next_bit_idx = bit_idx;
        next_shreg   = shreg;
        if (accept) begin
            next_state   = TX;
            next_cnt     = '0;
            next_bit_idx = '0;
            next_shreg   = data_in;
        end else if (en && (state == TX)) begin
            if (cnt == CNT_LAST) begin
                next_cnt = '0;
                if (bit_idx == BIT_LAST) begin
                    next_state   = IDLE;
                    next_bit_idx = '0;
                end else begin
                    next_bit_idx = bit_idx + 1'b1;
                    next_shreg   = shreg >> 1;
                end
            end else begin
                next_cnt = cnt + 1'b1;
            end
        end
    end

`ifdef BPSK_DIFF_EN
    logic diff_bit, next_diff_bit, bit_start;

    assign bit_start     = accept || (en && (state == TX) && (cnt == CNT_LAST) && (bit_idx != BIT_LAST));
    assign next_diff_bit = bit_start ? (next_shreg[0] ^ diff_bit) : diff_bit;
    assign tx_bit        = next_diff_bit;

    // Remember the last transmitted bit; it carries over from word to word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            diff_bit <= 1'b0;
        end else if (en) begin
            diff_bit <= next_diff_bit;
        end
    end
`else
    assign tx_bit = next_shreg[0];
`endif

    // The table is addressed with the next index so its registered output
    // lines up with cnt_out.
    sine_lut #(
        .SAMPLE_NUMBER (SAMPLE_NUMBER),
        .SAMPLE_WIDTH  (SAMPLE_WIDTH)
    ) u_sine_lut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .idx      (next_cnt),
        .value    (lut_value),
        .sine     (sine_out),
        .neg_sine (neg_sine_out)
    );

    // State registers and the modulated output sample, all frozen while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            signal_out <= MID;
        end else if (en) begin
            state      <= next_state;
            cnt        <= next_cnt;
            bit_idx    <= next_bit_idx;
            shreg      <= next_shreg;
            signal_out <= (next_state == TX) ? (tx_bit ? lut_value : ~lut_value) : MID;
        end
    end

endmodule

// File: tb/tb_bpsk_modulator.sv
// tb_bpsk_modulator -- self-checking bench for bpsk_modulator.
// A behavioural model tracks each word as a flat sample position and derives
// every output from the sine formula; a compare process checks all outputs on
// every falling edge. Directed scenarios add hand-computed literal checks.
// Honours BPSK_DIFF_EN in the model when the macro is defined.
module tb_bpsk_modulator;

    localparam int N    = 256;
    localparam int W    = 12;
    localparam int DW   = 12;
    localparam int CW   = $clog2(N);
    localparam int MID  = 2 ** (W - 1);
    localparam int AMP  = MID - 1;
    localparam int MAXV = 2 ** W - 1;
    localparam int LAST = DW * N - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [W-1:0]  signal_out;
    logic [W-1:0]  sine_out;
    logic [W-1:0]  neg_sine_out;
    logic [CW-1:0] cnt_out;
    logic          busy;

    bpsk_modulator #(
        .SAMPLE_NUMBER (N),
        .SAMPLE_WIDTH  (W),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .signal_out   (signal_out),
        .sine_out     (sine_out),
        .neg_sine_out (neg_sine_out),
        .cnt_out      (cnt_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Ideal offset-binary carrier sample k of an N-point period.
    function automatic int exp_sine(input int k);
        real s;
        s = $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
        return $rtoi($floor(real'(MID) + real'(AMP) * s + 0.5));
    endfunction

    // ---------------- behavioural model ----------------
    bit            m_busy = 1'b0;
    int            m_p    = 0;
    logic [DW-1:0] m_enc  = '0;
    logic          m_prev = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        logic [DW-1:0] enc_v;
        logic          prev_v;
        if (!rst) begin
            m_busy <= 1'b0;
            m_p    <= 0;
            m_prev <= 1'b0;
        end else if (en) begin
            if ((!m_busy || m_p == LAST) && data_valid) begin
                prev_v = m_prev;
                for (int i = 0; i < DW; i++) begin
`ifdef BPSK_DIFF_EN
                    prev_v   = data_in[i] ^ prev_v;
                    enc_v[i] = prev_v;
`else
                    enc_v[i] = data_in[i];
`endif
                end
                m_enc  <= enc_v;
                m_prev <= prev_v;
                m_busy <= 1'b1;
                m_p    <= 0;
            end else if (m_busy) begin
                if (m_p == LAST) begin
                    m_busy <= 1'b0;
                    m_p    <= 0;
                end else begin
                    m_p <= m_p + 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int k;
        int s;
        if (cmp_on) begin
            k = m_busy ? (m_p % N) : 0;
            s = exp_sine(k);
            check("cnt_out", int'(cnt_out), k);
            check("sine_out", int'(sine_out), s);
            check("neg_sine_out", int'(neg_sine_out), MAXV - s);
            check("signal_out", int'(signal_out), m_busy ? (m_enc[m_p / N] ? s : MAXV - s) : MID);
            check("busy", int'(busy), int'(m_busy));
            check("data_ready", int'(data_ready), int'(!m_busy || (m_p == LAST && en)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic offer(input logic [DW-1:0] w, input bit hold, input string name);
        data_in    = w;
        data_valid = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (data_ready && en) begin
                @(posedge clk);
                #1;
                if (!hold) begin
                    data_valid = 1'b0;
                    data_in    = DW'($urandom);
                end
                return;
            end
        end
        check({name, "_accept_timeout"}, 1, 0);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic check_idle_literals(input string name);
        check({name, "_ready"}, int'(data_ready), 1);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_signal"}, int'(signal_out), 2048);
        check({name, "_cnt"}, int'(cnt_out), 0);
        check({name, "_sine"}, int'(sine_out), 2048);
        check({name, "_neg"}, int'(neg_sine_out), 2047);
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        int            n;
        bit            acc;
        logic [DW-1:0] mask;

        rst        = 1'b0;
        en         = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        #1 cmp_on  = 1'b1;

        // Reset for three cycles, then idle.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_idle_literals("reset_idle");

        // Single word 0xA5C: first period inverted, third period true carrier.
        offer(12'hA5C, 1'b0, "a5c");
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (m_busy && m_p == 64)      check("a5c_bit0_peak", int'(signal_out), 0);
            if (m_busy && m_p == 2*N + 64) check("a5c_bit2_peak", int'(signal_out), 4095);
        end
        check("a5c_length", n, 3072);

        // Back-to-back 0xFFF then 0x000 with valid held.
        offer(12'hFFF, 1'b1, "b2b_first");
        data_in = 12'h000;
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            n++;
            if (data_ready && en) break;
        end
        check("b2b_ready_position", n, 3072);
        check("b2b_ready_cnt", int'(cnt_out), 255);
        @(posedge clk);
        #1 data_valid = 1'b0;
        @(negedge clk);
        check("b2b_restart_cnt", int'(cnt_out), 0);
        check("b2b_restart_busy", int'(busy), 1);
`ifndef BPSK_DIFF_EN
        check("b2b_restart_signal", int'(signal_out), 2047);
`endif
        wait_idle("b2b_second");

        // en toggled every cycle: each sample held two cycles.
        offer(DW'($urandom), 1'b0, "toggle");
        en = 1'b0;
        n  = 0;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            @(posedge clk);
            #1 en = ~en;
        end
        check("toggle_length", n, 6144);
        en = 1'b1;
        wait_idle("toggle");

        // Asynchronous reset at bit 5, sample 100, then a fresh word.
        offer(DW'($urandom), 1'b0, "abort");
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (m_busy && m_p == 5*N + 100) break;
        end
        check("abort_reached_cnt", int'(cnt_out), 100);
        #2 rst = 1'b0;
        #1 check_idle_literals("async_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        offer(12'h001, 1'b0, "after_reset");
        @(negedge clk);
        check("after_reset_cnt", int'(cnt_out), 0);
        check("after_reset_busy", int'(busy), 1);
`ifdef BPSK_DIFF_EN
        mask = 12'hFFF;
`else
        mask = 12'h001;
`endif
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (m_busy && (m_p % N) == 64)
                check("word001_peak", int'(signal_out), mask[m_p / N] ? 4095 : 0);
        end

        // Random traffic: random en duty, random word arrival, gapless allowed.
        acc = 1'b0;
        for (int c = 0; c < 16000; c++) begin
            @(negedge clk);
            acc = data_valid && data_ready && en;
            @(posedge clk);
            #1;
            if (acc) begin
                data_valid = 1'b0;
                data_in    = DW'($urandom);
            end
            en = ($urandom_range(3) != 0);
            if (!data_valid && $urandom_range(7) == 0) begin
                data_in    = DW'($urandom);
                data_valid = 1'b1;
            end
        end
        en         = 1'b1;
        data_valid = 1'b0;
        wait_idle("random");
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bpsk_modulator.md
BPSK_MODULATOR -- requirements
Module: bpsk_modulator

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256, giving samples per carrier period (one period per bit; power of two).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12, giving sample width in bits (unsigned offset binary).
REQ-003 SHALL have parameter DATA_WIDTH, default 12, giving bits per transmitted word.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port en, input, 1, sample-rate enable; when low, all state and outputs hold.
REQ-007 SHALL have port data_in, input, DATA_WIDTH, word to transmit.
REQ-008 SHALL have port data_valid, input, 1, data_in valid.
REQ-009 SHALL have port data_ready, output, 1, block accepts a word this cycle.
REQ-010 SHALL have port signal_out, output, SAMPLE_WIDTH, modulated BPSK sample.
REQ-011 SHALL have port sine_out, output, SAMPLE_WIDTH, reference carrier sample.
REQ-012 SHALL have port neg_sine_out, output, SAMPLE_WIDTH, inverted reference carrier sample.
REQ-013 SHALL have port cnt_out, output, clog2(SAMPLE_NUMBER), carrier phase index.
REQ-014 SHALL have port busy, output, 1, high while in TX.

Function
REQ-015 SHALL implement FSM with states IDLE and TX.
REQ-016 In IDLE: data_ready=1, cnt_out=0, signal_out=2^(SAMPLE_WIDTH-1) (midscale), sine_out=LUT[0], busy=0.
REQ-017 Handshake: word accepted on a rising edge where data_valid & data_ready & en; word latched into shift register, bit index=0, cnt=0, state->TX.
REQ-018 data_ready SHALL be 0 in TX except in the last sample of the last bit (bit index DATA_WIDTH-1, cnt SAMPLE_NUMBER-1) while en=1.
REQ-019 In TX: on each en cycle cnt increments, wrapping SAMPLE_NUMBER-1 -> 0; at wrap bit index increments.
REQ-020 Bits SHALL be sent LSB first; bit 1 -> signal_out=sine_out, bit 0 -> signal_out=neg_sine_out.
REQ-021 neg_sine_out SHALL equal bitwise complement of sine_out (mirror about midscale), every cycle.
REQ-022 sine_out, neg_sine_out, signal_out, cnt_out SHALL be registered and mutually aligned: the sample for index k appears in the same cycle as cnt_out==k.
REQ-023 At end of last bit: if a word is accepted (REQ-018), next word starts with cnt=0 the next cycle with no gap; otherwise state->IDLE.
REQ-024 data_valid while not data_ready SHALL be ignored; data_in need not be held after acceptance.
REQ-025 en low mid-word SHALL freeze cnt, bit index, and outputs; resume exactly where stopped.

Reset
REQ-026 On rst low, asynchronously: state=IDLE, cnt=0, bit index=0, shift register=0, outputs per REQ-016, differential state=0.
REQ-027 Reset mid-word SHALL abandon the word; no partial-word resume.

Configuration
REQ-028 Macro BPSK_DIFF_EN, when defined, SHALL differentially encode: transmitted bit = data bit XOR previous transmitted bit (previous = 0 after reset, persists across words).
REQ-029 Without BPSK_DIFF_EN, transmitted bit SHALL equal data bit.

Structure
REQ-030 Package bpsk_pkg SHALL hold FSM state encoding and default SAMPLE_NUMBER/SAMPLE_WIDTH/DATA_WIDTH constants shared with the demodulator.
REQ-031 Sub-module sine_lut SHALL provide the registered quarter-wave-symmetric sine table indexed by cnt, offset-binary, amplitude 2^(SAMPLE_WIDTH-1)-1.

Verification
REQ-032 Reset then idle: rst low 3 cycles, en=1 -> data_ready=1, busy=0, signal_out=2048, cnt_out=0.
REQ-033 Single word 12'hA5C, valid 1 cycle -> 12x256 samples; bit0=0 so first period signal_out==neg_sine_out; bit2=1 so third period signal_out==sine_out; then IDLE.
REQ-034 Back-to-back 12'hFFF then 12'h000 with valid held -> data_ready pulses once at cnt=255 of bit 11; cnt_out 255 -> 0 with no idle cycle; polarity flips.
REQ-035 en toggled 1/0 every cycle during word -> each cnt value held exactly 2 cycles; total 6144 cycles per word.
REQ-036 rst asserted at bit 5, cnt 100 -> outputs to IDLE values same cycle (asynchronous); next word starts at bit 0.
REQ-037 With BPSK_DIFF_EN, word 12'h001 -> transmitted bits all 1 (sine_out for all 12 periods); loopback to bpsk_demodulator recovers encoded word.
